// File: rtl/idex_pipe_reg_if.sv
// rtl/idex_pipe_reg_if.sv - decode/execute handshake bundle for the ID/EX stage register
interface idex_pipe_reg_if #(
    parameter int PAYLOAD_W = 181
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [PAYLOAD_W-1:0] out_data;

    // Environment side: drives decode beats and the execute-side ready
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // Stage register side
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/idex_pipe_reg.sv
// rtl/idex_pipe_reg.sv - parametrised ID/EX stage register with handshake, flush, skid entry and stall counter
module idex_pipe_reg #(
    parameter int PAYLOAD_W = 181,
    parameter int SKID      = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    idex_pipe_reg_if.slave   bus,
    input  logic             flush,
    input  logic             stall_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_out_valid;
    logic                 r_in_ready;
    logic [PAYLOAD_W-1:0] r_main_data;
    logic [PAYLOAD_W-1:0] r_skid_data;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic w_in_ready;
    logic w_in_xfer;
    logic w_out_xfer;
    logic w_stalled;
    logic w_cnt_sat;

    // With a skid entry in_ready comes straight from a flop; without one it
    // must look at out_ready so a beat can be replaced while it drains.
    assign w_in_ready = (SKID != 0) ? r_in_ready : (~r_out_valid | bus.out_ready);

    // A beat offered during a flush is dropped even when in_ready is high.
    assign w_in_xfer  = bus.in_valid & w_in_ready & ~flush;
    assign w_out_xfer = r_out_valid & bus.out_ready;
    assign w_stalled  = r_out_valid & ~bus.out_ready;
    assign w_cnt_sat  = &r_stall_cnt;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_main_data;
    assign stall_cnt     = r_stall_cnt;

    // Occupancy FSM: main register feeds execute, skid catches the beat that
    // arrives in the cycle in_ready was still high but execute stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main_data <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (SKID == 0) begin
            if (w_in_xfer) begin
                r_main_data <= bus.in_data;
                r_out_valid <= 1'b1;
                r_state     <= ST_ONE;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
                r_state     <= ST_EMPTY;
            end
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_main_data <= bus.in_data;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main_data <= bus.in_data;
                    end else if (w_in_xfer) begin
                        r_skid_data <= bus.in_data;
                        r_in_ready  <= 1'b0;
                        r_state     <= ST_FULL;
                    end else if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_xfer) begin
                        r_main_data <= r_skid_data;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Saturating count of back-pressured cycles; clear wins over a stall.
    always_ff @(posedge clk) begin
        if (rst || stall_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stalled && !w_cnt_sat) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_idex_pipe_reg.sv
// tb/tb_idex_pipe_reg.sv - directed self-checking bench for idex_pipe_reg
module tb_idex_pipe_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_rst, s_flush, s_clr;
    logic [15:0] s_cnt;
    logic        b_rst, b_flush, b_clr;
    logic [3:0]  b_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    idex_pipe_reg_if #(.PAYLOAD_W(181)) s_if ();
    idex_pipe_reg_if #(.PAYLOAD_W(16))  b_if ();

    idex_pipe_reg #(.PAYLOAD_W(181), .SKID(1), .CNT_W(16)) u_skid (
        .clk       (clk),
        .rst       (s_rst),
        .bus       (s_if.slave),
        .flush     (s_flush),
        .stall_clr (s_clr),
        .stall_cnt (s_cnt)
    );

    idex_pipe_reg #(.PAYLOAD_W(16), .SKID(0), .CNT_W(4)) u_byp (
        .clk       (clk),
        .rst       (b_rst),
        .bus       (b_if.slave),
        .flush     (b_flush),
        .stall_clr (b_clr),
        .stall_cnt (b_cnt)
    );

    task automatic chk(input string tag, input logic [180:0] obs, input logic [180:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_rst = 1'b1; s_flush = 1'b0; s_clr = 1'b0;
        b_rst = 1'b1; b_flush = 1'b0; b_clr = 1'b0;
        s_if.in_valid = 1'b0; s_if.in_data = '0; s_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_s_out_valid", 181'(s_if.out_valid), 181'(0));
        chk("rst_s_out_data",  s_if.out_data, 181'(0));
        chk("rst_s_in_ready",  181'(s_if.in_ready), 181'(1));
        chk("rst_s_stall",     181'(s_cnt), 181'(0));
        chk("rst_b_out_valid", 181'(b_if.out_valid), 181'(0));
        chk("rst_b_in_ready",  181'(b_if.in_ready), 181'(1));
        chk("rst_b_stall",     181'(b_cnt), 181'(0));
        s_rst = 1'b0;
        b_rst = 1'b0;

        // Streaming 0x1..0x8 with execute always ready
        s_if.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_if.in_valid = 1'b1;
            s_if.in_data  = 181'(i);
            tick();
            chk("stream_data",     s_if.out_data, 181'(i));
            chk("stream_valid",    181'(s_if.out_valid), 181'(1));
            chk("stream_in_ready", 181'(s_if.in_ready), 181'(1));
        end
        s_if.in_valid = 1'b0;
        tick();
        chk("stream_drained", 181'(s_if.out_valid), 181'(0));
        chk("stream_stall",   181'(s_cnt), 181'(0));

        // Back-pressure: A into main, B into skid, C held by source
        s_if.out_ready = 1'b0;
        s_if.in_valid  = 1'b1;
        s_if.in_data   = 181'h0A;
        tick();
        chk("bp_a_main",     s_if.out_data, 181'h0A);
        chk("bp_a_in_ready", 181'(s_if.in_ready), 181'(1));
        s_if.in_data = 181'h0B;
        tick();
        chk("bp_b_in_ready", 181'(s_if.in_ready), 181'(0));
        chk("bp_b_main",     s_if.out_data, 181'h0A);
        s_if.in_data = 181'h0C;
        tick();
        chk("bp_c_held_main", s_if.out_data, 181'h0A);
        chk("bp_c_in_ready",  181'(s_if.in_ready), 181'(0));
        chk("bp_stall",       181'(s_cnt), 181'(2));
        s_if.out_ready = 1'b1;
        tick();
        chk("bp_out_b",       s_if.out_data, 181'h0B);
        chk("bp_out_b_valid", 181'(s_if.out_valid), 181'(1));
        chk("bp_ready_again", 181'(s_if.in_ready), 181'(1));
        tick();
        chk("bp_out_c", s_if.out_data, 181'h0C);
        s_if.in_valid = 1'b0;
        tick();
        chk("bp_empty",       181'(s_if.out_valid), 181'(0));
        chk("bp_stall_final", 181'(s_cnt), 181'(2));

        // Flush while FULL with a new beat offered
        s_if.out_ready = 1'b0;
        s_if.in_valid  = 1'b1;
        s_if.in_data   = 181'h11;
        tick();
        s_if.in_data = 181'h22;
        tick();
        chk("fl_full", 181'(s_if.in_ready), 181'(0));
        s_flush      = 1'b1;
        s_if.in_data = 181'h33;
        tick();
        chk("fl_out_valid", 181'(s_if.out_valid), 181'(0));
        chk("fl_in_ready",  181'(s_if.in_ready), 181'(1));
        s_flush        = 1'b0;
        s_if.in_valid  = 1'b0;
        s_if.out_ready = 1'b1;
        tick();
        chk("fl_no_33",   181'(s_if.out_valid), 181'(0));
        chk("fl_stall",   181'(s_cnt), 181'(4));
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        chk("fl_clr", 181'(s_cnt), 181'(0));

        // Reset mid-stream while FULL
        s_if.out_ready = 1'b0;
        s_if.in_valid  = 1'b1;
        s_if.in_data   = 181'h44;
        tick();
        s_if.in_data = 181'h55;
        tick();
        chk("rm_full_stall", 181'(s_cnt), 181'(1));
        s_rst         = 1'b1;
        s_if.in_valid = 1'b0;
        tick();
        chk("rm_out_valid", 181'(s_if.out_valid), 181'(0));
        chk("rm_out_data",  s_if.out_data, 181'(0));
        chk("rm_stall",     181'(s_cnt), 181'(0));
        chk("rm_in_ready",  181'(s_if.in_ready), 181'(1));
        s_rst          = 1'b0;
        s_if.in_valid  = 1'b1;
        s_if.in_data   = 181'h66;
        s_if.out_ready = 1'b1;
        tick();
        chk("rm_first_valid", 181'(s_if.out_valid), 181'(1));
        chk("rm_first_data",  s_if.out_data, 181'h66);
        s_if.in_valid = 1'b0;
        tick();

        // Bypass mode: in_ready follows out_ready combinationally
        b_if.in_valid = 1'b1;
        b_if.in_data  = 16'h005A;
        tick();
        b_if.in_valid = 1'b0;
        #1;
        chk("by_valid",       181'(b_if.out_valid), 181'(1));
        chk("by_data",        181'(b_if.out_data), 181'h5A);
        chk("by_ready_low",   181'(b_if.in_ready), 181'(0));
        b_if.out_ready = 1'b1;
        #1;
        chk("by_ready_high",  181'(b_if.in_ready), 181'(1));
        b_if.in_valid = 1'b1;
        b_if.in_data  = 16'h005B;
        tick();
        chk("by_reload_data",  181'(b_if.out_data), 181'h5B);
        chk("by_reload_valid", 181'(b_if.out_valid), 181'(1));
        chk("by_stall_zero",   181'(b_cnt), 181'(0));

        // Saturating counter on a 4-bit stall count
        b_if.in_valid  = 1'b0;
        b_if.out_ready = 1'b0;
        repeat (14) tick();
        chk("cnt_14", 181'(b_cnt), 181'(14));
        repeat (6) tick();
        chk("cnt_sat",    181'(b_cnt), 181'(15));
        chk("cnt_stable", 181'(b_if.out_data), 181'h5B);
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        chk("cnt_clr", 181'(b_cnt), 181'(0));
        tick();
        chk("cnt_1", 181'(b_cnt), 181'(1));
        tick();
        chk("cnt_2", 181'(b_cnt), 181'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
